// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller built around a single full adder.
// Adds op_a + op_b + cin one bit per clock, LSB first, then pulses done.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   start           - begin an addition (only sampled in IDLE)
//   op_a, op_b, cin - operands and carry-in, captured on the accept edge
//   busy            - high while the adder is stepping through bits
//   done            - one-cycle pulse when result/cout/ovf are updated
//   result          - WIDTH-bit sum of the last completed addition
//   cout, ovf       - carry-out and two's-complement overflow of that addition

// Single-bit full adder; the only arithmetic element of the datapath.
module serial_add_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] sum_next;

    serial_add_fa u_fa (
        .a  (a_q[0]),
        .b  (b_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // New sum bit enters at the MSB so after WIDTH shifts bit 0 is the LSB.
    assign sum_next = {fa_s, sum_q[WIDTH-1:1]};

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_d    = sum_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    carry_d = cin;
                    sum_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d   = sum_next;
                carry_d = fa_co;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // carry_q is the carry into the MSB here, fa_co the carry out.
                    result_d = sum_next;
                    cout_d   = fa_co;
                    ovf_d    = carry_q ^ fa_co;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sum_q    <= sum_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: randomized and directed bench for serial_add_ctrl (WIDTH=8).
// A transaction-level model predicts busy/done timing from elapsed cycles since
// the accept edge and the results from plain integer addition.
module tb_serial_add_ctrl;
    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: cycles since accept (0 = idle), pending operands, visible results.
    int          m_cyc = 0;
    int unsigned m_a, m_b, m_c;
    int unsigned m_res, m_cout, m_ovf;
    int          m_done_cnt = 0;
    int          dut_done_cnt = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op_a   (op_a),
        .op_b   (op_b),
        .cin    (cin),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_cyc  = 0;
        m_res  = 0;
        m_cout = 0;
        m_ovf  = 0;
    endtask

    task automatic check_outputs();
        check("busy",   32'(busy),   32'((m_cyc >= 1) && (m_cyc <= W)));
        check("done",   32'(done),   32'(m_cyc == W + 1));
        check("result", 32'(result), m_res);
        check("cout",   32'(cout),   m_cout);
        check("ovf",    32'(ovf),    m_ovf);
    endtask

    // One clock edge: advance the model, then compare 1 time unit later.
    task automatic step();
        int unsigned s, msb_a, msb_b, msb_s;
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else if (m_cyc == 0) begin
            if (start) begin
                m_cyc = 1;
                m_a   = 32'(op_a);
                m_b   = 32'(op_b);
                m_c   = 32'(cin);
            end
        end else if (m_cyc == W + 1) begin
            m_cyc = 0;
        end else begin
            m_cyc++;
            if (m_cyc == W + 1) begin
                s      = m_a + m_b + m_c;
                msb_a  = (m_a >> (W - 1)) & 1;
                msb_b  = (m_b >> (W - 1)) & 1;
                msb_s  = (s >> (W - 1)) & 1;
                m_res  = s & ((1 << W) - 1);
                m_cout = (s >> W) & 1;
                m_ovf  = 32'((msb_a == msb_b) && (msb_s != msb_a));
                m_done_cnt++;
            end
        end
        #1;
        if (done) dut_done_cnt++;
        check_outputs();
    endtask

    task automatic scramble();
        op_a = W'($urandom);
        op_b = W'($urandom);
        cin  = 1'($urandom);
    endtask

    // Issue one op; during RUN/DONE start and operands are randomized (must be ignored).
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        op_a  = a;
        op_b  = b;
        cin   = c;
        start = 1'b1;
        step();
        for (int i = 0; i < W + 1; i++) begin
            start = 1'($urandom);
            scramble();
            step();
        end
        start = 1'b0;
    endtask

    task automatic do_op_chk(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic c, input logic [W-1:0] er, input logic ec,
                             input logic eo);
        do_op(a, b, c);
        check({tag, "_res"},  32'(result), 32'(er));
        check({tag, "_cout"}, 32'(cout),   32'(ec));
        check({tag, "_ovf"},  32'(ovf),    32'(eo));
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        cin   = 1'b0;
        model_clear();
        #1;
        check_outputs();
        step();
        step();
        @(negedge clk);
        rst = 1'b0;

        // Directed cases; first start lands on the first edge after reset.
        do_op_chk("s0f01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
        do_op_chk("sff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        do_op_chk("s7f01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        do_op_chk("sffff", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
        do_op_chk("s8080", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        step();
        step();

        // Abort in the 4th RUN cycle with an asynchronous reset.
        op_a  = 8'h12;
        op_b  = 8'h34;
        cin   = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            scramble();
            step();
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_clear();
        check_outputs();
        step();
        step();
        @(negedge clk);
        rst = 1'b0;
        do_op_chk("s1234", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

        // Random back-to-back operations with idle gaps.
        for (int k = 0; k < 60; k++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom));
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                scramble();
                step();
            end
        end

        // start held high: one completion every W+2 cycles.
        start = 1'b1;
        for (int i = 0; i < 10 * (W + 2); i++) begin
            scramble();
            step();
        end
        start = 1'b0;
        for (int i = 0; i < W + 3; i++) step();

        check("done_pulses", 32'(dut_done_cnt), 32'(m_done_cnt));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

endmodule
